// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage types and constants.
// Entry layout, word size and the PC increment helper.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Width of the count of in-flight responses owed to a dead stream.
  localparam int DISC_W = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] code;
  } fq_entry_t;

  function automatic logic [XLEN-1:0] pc_next(
    input logic [XLEN-1:0] pc
  );
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fq_storage.sv
// fq_storage: DEPTH x {pc,code} register file for the fetch queue.
// Ports: pc write (alloc), code write (fill), async read (head), async clear.
module fq_storage
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            pc_we_i,
  input  logic [IW-1:0]   pc_waddr_i,
  input  logic [XLEN-1:0] pc_wdata_i,
  input  logic            code_we_i,
  input  logic [IW-1:0]   code_waddr_i,
  input  logic [XLEN-1:0] code_wdata_i,
  input  logic [IW-1:0]   raddr_i,
  output logic [XLEN-1:0] rd_pc_o,
  output logic [XLEN-1:0] rd_code_o
);

  fq_entry_t mem_q [DEPTH];

  // The pc half is written at reservation, the code half
  // when the matching response lands; they never collide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (pc_we_i) begin
        mem_q[pc_waddr_i].pc <= pc_wdata_i;
      end
      if (code_we_i) begin
        mem_q[code_waddr_i].code <= code_wdata_i;
      end
    end
  end

  assign rd_pc_o   = mem_q[raddr_i].pc;
  assign rd_code_o = mem_q[raddr_i].code;

endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential fetch with reservation prefetch queue.
// Ports: imem req/rsp, redirect, instr valid/ready to decode, occupancy.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [31:0]            imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [31:0]            imem_rsp_data,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [31:0]            instr_code,
  output logic [31:0]            instr_pc,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]     alloc_q, alloc_d;
  logic [PW-1:0]     fill_q, fill_d;
  logic [PW-1:0]     head_q, head_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [DISC_W-1:0] discard_q, discard_d;

  logic [PW-1:0] used;
  logic [PW-1:0] inflight;
  logic          req_fire;
  logic          rsp_drop;
  logic          rsp_keep;
  logic          pop;

  // Reserved entries and reservations still waiting for data.
  assign used     = alloc_q - head_q;
  assign inflight = alloc_q - fill_q;

  // Gated by reset so the request drops as soon as reset asserts.
  assign imem_req_valid = reset
                        && (used < PW'(DEPTH))
                        && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A word owed to a flushed stream is never stored.
  assign rsp_drop = imem_rsp_valid
                  && (discard_q != '0 || redirect_valid);
  assign rsp_keep = imem_rsp_valid && !rsp_drop;

  assign instr_valid = (head_q != fill_q) && !redirect_valid;
  assign pop         = instr_valid && instr_ready;
  assign occupancy   = used;

  always_comb begin
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    head_d     = head_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;

    if (req_fire) begin
      alloc_d    = alloc_q + PW'(1);
      fetch_pc_d = pc_next(fetch_pc_q);
    end
    if (rsp_keep) begin
      fill_d = fill_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (imem_rsp_valid && discard_q != '0) begin
      discard_d = discard_q - DISC_W'(1);
    end

    // Every reservation not yet filled becomes a response to
    // throw away; one arriving now is already accounted for.
    if (redirect_valid) begin
      alloc_d    = '0;
      fill_d     = '0;
      head_d     = '0;
      fetch_pc_d = redirect_pc;
      discard_d  = discard_q
                 + DISC_W'(inflight)
                 - DISC_W'(imem_rsp_valid);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alloc_q    <= '0;
      fill_q     <= '0;
      head_q     <= '0;
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else begin
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      head_q     <= head_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  fq_storage #(
    .DEPTH(DEPTH)
  ) u_storage (
    .clk_i        (clock),
    .rst_ni       (reset),
    .pc_we_i      (req_fire),
    .pc_waddr_i   (alloc_q[IW-1:0]),
    .pc_wdata_i   (fetch_pc_q),
    .code_we_i    (rsp_keep),
    .code_waddr_i (fill_q[IW-1:0]),
    .code_wdata_i (imem_rsp_data),
    .raddr_i      (head_q[IW-1:0]),
    .rd_pc_o      (instr_pc),
    .rd_code_o    (instr_code)
  );

  // A response must belong to a reservation or a flushed stream.
  a_rsp_owned: assert property (
    @(posedge clock) disable iff (!reset)
      imem_rsp_valid |-> (inflight != '0 || discard_q != '0)
  );

  a_addr_hold: assert property (
    @(posedge clock) disable iff (!reset)
      (imem_req_valid && !imem_req_ready)
        |=> (imem_req_addr == $past(imem_req_addr))
  );

  a_credit: assert property (
    @(posedge clock) disable iff (!reset)
      used <= PW'(DEPTH)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed table + sequence bench for the fetch queue.
// Behavioural imem with programmable latency, output and request logs.
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_code;
  logic [31:0] instr_pc;
  logic [2:0]  occupancy;

  int n_cmp = 0;
  int n_bad = 0;
  int mem_lat = 1;

  always #5 clock = ~clock;

  instr_fetch_queue #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_code     (instr_code),
    .instr_pc       (instr_pc),
    .occupancy      (occupancy)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd7) ^ 32'h0000_0013;
  endfunction

  // Memory: in-order responses, mem_lat cycles after acceptance.
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          mcyc;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_addr.delete();
      pend_due.delete();
      mcyc <= 0;
      imem_rsp_valid <= 1'b0;
      imem_rsp_data <= 32'h0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(mcyc + mem_lat - 1);
      end
      if (pend_due.size() > 0 && pend_due[0] <= mcyc) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data <= mem_word(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
      mcyc <= mcyc + 1;
    end
  end

  // Logs of consumed instructions and accepted requests.
  logic [31:0] out_pc[$];
  logic [31:0] out_code[$];
  logic [31:0] acc_addr[$];

  always @(negedge clock) begin
    if (reset) begin
      if (instr_valid && instr_ready) begin
        out_pc.push_back(instr_pc);
        out_code.push_back(instr_code);
      end
      if (imem_req_valid && imem_req_ready) begin
        acc_addr.push_back(imem_req_addr);
      end
      assert (occupancy <= 3'(DEPTH))
        else $error("occupancy above DEPTH: %0d", occupancy);
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle 0 after release.
  task automatic do_reset();
    reset = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    mem_lat = 1;
    repeat (2) @(posedge clock);
    out_pc.delete();
    out_code.delete();
    acc_addr.delete();
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    logic        ir;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] pc;
    logic [2:0]  occ;
  } vec_t;

  vec_t tv[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 3'd0};
    tv[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 3'd1};
    tv[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 3'd2};
    tv[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 3'd2};
    tv[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08, 3'd2};
    tv[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C, 3'd2};
    tv[6]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h0C, 3'd3};
    tv[7]  = '{1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C, 3'd4};
    tv[8]  = '{1'b1, 1'b0, 32'h1C, 1'b1, 32'h0C, 3'd4};
    tv[9]  = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h10, 3'd3};
    tv[10] = '{1'b0, 1'b0, 32'h20, 1'b1, 32'h10, 3'd4};
    tv[11] = '{1'b0, 1'b0, 32'h20, 1'b1, 32'h10, 3'd4};

    // Reset state while reset is held.
    @(negedge clock);
    chk("rst.req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst.req_addr", imem_req_addr, RESET_PC);
    chk("rst.instr_valid", 32'(instr_valid), 32'd0);
    chk("rst.instr_code", instr_code, 32'h0);
    chk("rst.instr_pc", instr_pc, 32'h0);
    chk("rst.occupancy", 32'(occupancy), 32'd0);

    // Streaming, then decode backpressure and a single pop.
    do_reset();
    imem_req_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      instr_ready = tv[i].ir;
      @(negedge clock);
      chk($sformatf("v%0d.req_valid", i),
          32'(imem_req_valid), 32'(tv[i].rv));
      chk($sformatf("v%0d.req_addr", i), imem_req_addr, tv[i].addr);
      chk($sformatf("v%0d.instr_valid", i),
          32'(instr_valid), 32'(tv[i].iv));
      chk($sformatf("v%0d.occupancy", i),
          32'(occupancy), 32'(tv[i].occ));
      if (tv[i].iv) begin
        chk($sformatf("v%0d.instr_pc", i), instr_pc, tv[i].pc);
        chk($sformatf("v%0d.instr_code", i),
            instr_code, mem_word(tv[i].pc));
      end
      cyc();
    end

    // From empty with decode stalled: exactly DEPTH requests.
    do_reset();
    imem_req_ready = 1'b1;
    instr_ready = 1'b0;
    repeat (8) cyc();
    instr_ready = 1'b1;
    @(negedge clock);
    chk("fill.accepts", 32'(acc_addr.size()), 32'd4);
    chk("fill.req_valid", 32'(imem_req_valid), 32'd0);
    chk("fill.occupancy", 32'(occupancy), 32'd4);
    chk("fill.instr_valid", 32'(instr_valid), 32'd1);
    cyc();
    instr_ready = 1'b0;
    @(negedge clock);
    chk("pop1.req_valid", 32'(imem_req_valid), 32'd1);
    chk("pop1.req_addr", imem_req_addr, 32'h10);
    cyc();

    // Latency 3; redirect with two responses still owed.
    do_reset();
    mem_lat = 3;
    instr_ready = 1'b1;
    imem_req_ready = 1'b1;
    cyc();
    cyc();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clock);
    chk("rd3.req_valid", 32'(imem_req_valid), 32'd0);
    chk("rd3.instr_valid", 32'(instr_valid), 32'd0);
    chk("rd3.outstanding", 32'(pend_addr.size()), 32'd2);
    cyc();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clock);
    chk("rd3.new_addr", imem_req_addr, 32'h100);
    repeat (14) cyc();
    chk("rd3.count", 32'(out_pc.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rd3.pc%0d", i),
          out_pc[i], 32'h100 + 32'(4 * i));
      chk($sformatf("rd3.code%0d", i),
          out_code[i], mem_word(32'h100 + 32'(4 * i)));
    end

    // Redirect coinciding with a response and a pop.
    do_reset();
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    repeat (5) cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clock);
    chk("rdp.rsp_present", 32'(imem_rsp_valid), 32'd1);
    chk("rdp.instr_valid", 32'(instr_valid), 32'd0);
    chk("rdp.req_valid", 32'(imem_req_valid), 32'd0);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clock);
    chk("rdp.next_valid", 32'(imem_req_valid), 32'd1);
    chk("rdp.next_addr", imem_req_addr, 32'h200);
    chk("rdp.occupancy", 32'(occupancy), 32'd0);
    chk("rdp.empty", 32'(instr_valid), 32'd0);
    cyc();
    @(negedge clock);
    chk("rdp.no_bypass", 32'(instr_valid), 32'd0);
    chk("rdp.old_pops", 32'(out_pc.size()), 32'd3);
    chk("rdp.last_old", out_pc[2], 32'h8);
    cyc();
    @(negedge clock);
    chk("rdp.first_valid", 32'(instr_valid), 32'd1);
    chk("rdp.first_pc", instr_pc, 32'h200);
    chk("rdp.first_code", instr_code, mem_word(32'h200));
    cyc();

    // Request stall holds address; PC wraps past 2^32.
    do_reset();
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    cyc();
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk($sformatf("hold%0d.valid", i), 32'(imem_req_valid), 32'd1);
      chk($sformatf("hold%0d.addr", i), imem_req_addr, 32'hFFFF_FFF8);
      cyc();
    end
    imem_req_ready = 1'b1;
    repeat (8) cyc();
    chk("wrap.count", 32'(out_pc.size() >= 4), 32'd1);
    chk("wrap.pc0", out_pc[0], 32'hFFFF_FFF8);
    chk("wrap.pc1", out_pc[1], 32'hFFFF_FFFC);
    chk("wrap.pc2", out_pc[2], 32'h0000_0000);
    chk("wrap.pc3", out_pc[3], 32'h0000_0004);
    chk("wrap.code2", out_code[2], mem_word(32'h0));

    // Asynchronous reset with three entries queued.
    do_reset();
    imem_req_ready = 1'b1;
    instr_ready = 1'b0;
    repeat (3) cyc();
    imem_req_ready = 1'b0;
    cyc();
    #1;
    chk("ar.pre_occ", 32'(occupancy), 32'd3);
    chk("ar.pre_valid", 32'(instr_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("ar.req_valid", 32'(imem_req_valid), 32'd0);
    chk("ar.req_addr", imem_req_addr, RESET_PC);
    chk("ar.instr_valid", 32'(instr_valid), 32'd0);
    chk("ar.instr_code", instr_code, 32'h0);
    chk("ar.instr_pc", instr_pc, 32'h0);
    chk("ar.occupancy", 32'(occupancy), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    @(negedge clock);
    chk("ar.restart_valid", 32'(imem_req_valid), 32'd1);
    chk("ar.restart_addr", imem_req_addr, RESET_PC);
    cyc();
    cyc();
    @(negedge clock);
    chk("ar.first_valid", 32'(instr_valid), 32'd1);
    chk("ar.first_pc", instr_pc, RESET_PC);
    chk("ar.first_code", instr_code, mem_word(RESET_PC));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
